exec_stage: RTL and testbench
=============================

# exec_stage

Execute stage sitting directly downstream of the 8×16-bit register file. It consumes the registered operand buses `BusA`/`BusB`, performs one ALU operation per accepted instruction, and drives the register file's write port (`enable_write`, `RW`, `BusW`). Single-cycle ops stream back-to-back. An optional iterative 16-cycle multiplier stalls the stage through a valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand and result width.
- `AW`, default 3: register address width.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous reset, active-high.
- `in_valid` in 1: opcode, `rd`, `BusA` and `BusB` are valid this cycle.
- `in_ready` out 1: stage accepts an instruction this cycle.
- `opcode` in 3: operation select.
- `rd` in `AW`: destination register.
- `BusA` in `WIDTH`: operand A, from the register file.
- `BusB` in `WIDTH`: operand B, from the register file.
- `enable_write` out 1: write strobe to the register file.
- `RW` out `AW`: write address.
- `BusW` out `WIDTH`: write data.
- `zero` out 1: last written result was 0.
- `busy` out 1: multiply in progress.

## Operation
- The register file reads are registered. The upstream controller therefore presents `RA`/`RB` one cycle early and asserts `in_valid` aligned with `BusA`/`BusB`.
- Accept occurs on a rising edge with `in_valid && in_ready`. On accept, the stage latches `opcode`, `rd`, `BusA` and `BusB`.
- Opcodes, all results modulo 2^16:
  - 000 ADD: A+B.
  - 001 SUB: A−B, two's complement.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << B[3:0], zero-fill.
  - 110 SRL: A >> B[3:0], zero-fill.
  - 111 MUL: low 16 bits of A×B.
- FSM states:
  - IDLE: an accepted non-MUL op writes back next cycle and the state stays IDLE. An accepted MUL loads the accumulator with 0 and the multiplier/multiplicand, clears the counter, and goes to MUL.
  - MUL: each cycle, the accumulator adds the multiplicand if multiplier bit 0 is set; then multiplicand <<= 1, multiplier >>= 1, and the counter increments. The state exits to IDLE when the counter reaches 15, registering the write-back.
- `enable_write` is a 1-cycle pulse per instruction. It is suppressed (held 0) when `rd` = 0, while `BusW`/`RW` still update.
- `zero` updates with every result, including when `rd` = 0.
- `in_ready` = (state == IDLE) && !`reset`.
- `busy` = (state == MUL).
- Reset, at any time including mid-multiply:
  - state IDLE, counter 0.
  - `enable_write`, `RW`, `BusW`, `zero` all driven 0.
  - An in-flight multiply is aborted with no write-back.
- `in_valid` while `in_ready` = 0 is ignored. Upstream must hold the instruction until accepted.

## Timing
- Single-cycle op accepted at edge N: `enable_write`/`RW`/`BusW`/`zero` are valid from edge N+1 for one cycle. Throughput is 1 op/cycle.
- MUL accepted at edge N:
  - `busy` and `!in_ready` hold during cycles N+1..N+16.
  - Iterations occur on edges N+1..N+16.
  - Write-back is valid from edge N+16 for one cycle.
  - `in_ready` is high again in the same cycle as the MUL write-back, so a new op can be accepted at edge N+17.
- Back-to-back writes use the same `RW`. The register file has synchronous write with read-before-write. The upstream controller owns forwarding and hazard stalls; this stage provides none.
- All outputs are registered. `in_ready` and `busy` are decoded from state.

## Configuration
- `EXEC_MUL_EN` defined:
  - Opcode 111 runs the iterative multiplier as above.
  - The MUL state, counter, accumulator and shift registers are present.
- `EXEC_MUL_EN` undefined:
  - Opcode 111 is a 1-cycle no-op: `enable_write` = 0, `BusW` = 0, `zero` = 1.
  - `busy` is tied 0 and `in_ready` = !`reset`.
  - No multiplier logic is present.

## Test plan
- Reset mid-stream: hold `reset` 2 cycles after activity -> `enable_write` = 0, `RW` = 0, `BusW` = 0, `zero` = 0, `in_ready` = 0 during reset and 1 after.
- Back-to-back single-cycle ops, issued one per cycle:
  - ADD 0xFFFF+0x0001 to r1 -> `BusW` = 0x0000, `zero` = 1.
  - SUB 0x0003−0x0005 to r2 -> `BusW` = 0xFFFE.
  - SLL 0x0001 by B = 0x0013 to r3 -> `BusW` = 0x0008.
  - Expected: three consecutive `enable_write` pulses with `RW` = 1, 2, 3.
- `rd` = 0: XOR 0x00FF^0x0F0F to r0 -> `BusW` = 0x0FF0, `enable_write` = 0.
- MUL, with `EXEC_MUL_EN`: 0x0123×0x0100 to r4 ->
  - `in_ready` low for 16 cycles.
  - `BusW` = 0x2300, `RW` = 4, single `enable_write` at accept+16.
  - A following ADD is accepted in the same cycle as the MUL write-back and writes back one cycle later.
- MUL aborted: `reset` asserted at accept+8 -> no `enable_write`, state IDLE, `in_ready` high after reset release.
- Without `EXEC_MUL_EN`: MUL 5×7 to r5 -> `in_ready` stays high, `enable_write` = 0, `BusW` = 0, `zero` = 1.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: execute stage feeding the 8x16 register file write port.
// Single-cycle ALU ops are latched on accept and written back one cycle later.
// Optional iterative shift-add multiplier (opcode 111) is enabled by defining
// EXEC_MUL_EN; without it opcode 111 is a one-cycle no-op.
module exec_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             enable_write,
  output logic [AW-1:0]    RW,
  output logic [WIDTH-1:0] BusW,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  logic accept;

  // Latched single-cycle instruction
  logic             pend_vld_q, pend_vld_d;
  op_e              pend_op_q,  pend_op_d;
  logic [AW-1:0]    pend_rd_q,  pend_rd_d;
  logic [WIDTH-1:0] pend_a_q,   pend_a_d;
  logic [WIDTH-1:0] pend_b_q,   pend_b_d;

  // Registered write-back port
  logic             we_q,   we_d;
  logic [AW-1:0]    rw_q,   rw_d;
  logic [WIDTH-1:0] busw_q, busw_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;

`ifdef EXEC_MUL_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e           state_q,  state_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_sum;

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign busy     = (state_q == S_MUL);
`else
  assign in_ready = !reset;
  assign busy     = 1'b0;
`endif

  assign accept       = in_valid && in_ready;
  assign enable_write = we_q;
  assign RW           = rw_q;
  assign BusW         = busw_q;
  assign zero         = zero_q;

  // Single-cycle ALU on the latched operands; opcode 111 yields 0 here
  always_comb begin
    alu_res = '0;
    case (pend_op_q)
      OP_ADD:  alu_res = pend_a_q + pend_b_q;
      OP_SUB:  alu_res = pend_a_q - pend_b_q;
      OP_AND:  alu_res = pend_a_q & pend_b_q;
      OP_OR:   alu_res = pend_a_q | pend_b_q;
      OP_XOR:  alu_res = pend_a_q ^ pend_b_q;
      OP_SLL:  alu_res = pend_a_q << pend_b_q[3:0];
      OP_SRL:  alu_res = pend_a_q >> pend_b_q[3:0];
      default: alu_res = '0;
    endcase
  end

  // Next-state: accept latch, write-back selection and multiplier iteration
  always_comb begin
    pend_vld_d = 1'b0;
    pend_op_d  = pend_op_q;
    pend_rd_d  = pend_rd_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    we_d       = 1'b0;
    rw_d       = rw_q;
    busw_d     = busw_q;
    zero_d     = zero_q;

    // rd is latched for every accepted op; the multiplier reuses it at write-back
    if (accept) begin
      pend_op_d = op_e'(opcode);
      pend_rd_d = rd;
      pend_a_d  = BusA;
      pend_b_d  = BusB;
`ifdef EXEC_MUL_EN
      pend_vld_d = (opcode != OP_MUL);
`else
      pend_vld_d = 1'b1;
`endif
    end

    if (pend_vld_q) begin
      we_d   = (pend_rd_q != '0) && (pend_op_q != OP_MUL);
      rw_d   = pend_rd_q;
      busw_d = alu_res;
      zero_d = (alu_res == '0);
    end

`ifdef EXEC_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept && (opcode == OP_MUL)) begin
          acc_d    = '0;
          mcand_d  = BusA;
          mplier_d = BusB;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        // The 16th iteration's sum goes straight to the write-back port
        if (cnt_q == 4'd15) begin
          state_d = S_IDLE;
          we_d    = (pend_rd_q != '0);
          rw_d    = pend_rd_q;
          busw_d  = acc_sum;
          zero_d  = (acc_sum == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  // State registers with synchronous reset; reset aborts any multiply
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_op_q  <= OP_ADD;
      pend_rd_q  <= '0;
      pend_a_q   <= '0;
      pend_b_q   <= '0;
      we_q       <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
      zero_q     <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
`endif
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      pend_rd_q  <= pend_rd_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      we_q       <= we_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
      zero_q     <= zero_d;
`ifdef EXEC_MUL_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage (default and EXEC_MUL_EN builds).
module tb_exec_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [2:0]  rd;
  logic [15:0] BusA;
  logic [15:0] BusB;
  logic        enable_write;
  logic [2:0]  RW;
  logic [15:0] BusW;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  exec_stage #(.WIDTH(16), .AW(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .BusA(BusA), .BusB(BusB),
    .enable_write(enable_write), .RW(RW), .BusW(BusW), .zero(zero), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] r,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid = v; opcode = op; rd = r; BusA = a; BusB = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    tick(); tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== 21'h0) begin
      bad++; $display("FAIL reset_init: got %h want %h", {enable_write, RW, BusW, zero}, 21'h0);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_init_ready: got %b want 0", in_ready); end
    // activity: ADD 0+0 -> r6, then OR -> r7 interrupted by reset
    reset = 1'b0;
    drive(1'b1, 3'b000, 3'd6, 16'h0000, 16'h0000);
    #1;
    tick();
    drive(1'b1, 3'b011, 3'd7, 16'h1200, 16'h0034);
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b1, 3'd6, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL pre_reset_wb: got %h want %h", {enable_write, RW, BusW, zero}, {1'b1, 3'd6, 16'h0000, 1'b1});
    end
    reset = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({enable_write, RW, BusW, zero, in_ready} !== 22'h0) begin
        bad++; $display("FAIL reset_hold%0d: got %h want 0", k, {enable_write, RW, BusW, zero, in_ready});
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    tick();
    total++;
    if (enable_write !== 1'b0) begin bad++; $display("FAIL reset_drop_wb: got %b want 0", enable_write); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b000, 3'd1, 16'hFFFF, 16'h0001);
    tick();
    drive(1'b1, 3'b001, 3'd2, 16'h0003, 16'h0005);
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b1, 3'd1, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL b2b_add: got %h want %h", {enable_write, RW, BusW, zero}, {1'b1, 3'd1, 16'h0000, 1'b1});
    end
    drive(1'b1, 3'b101, 3'd3, 16'h0001, 16'h0013);
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b1, 3'd2, 16'hFFFE, 1'b0}) begin
      bad++; $display("FAIL b2b_sub: got %h want %h", {enable_write, RW, BusW, zero}, {1'b1, 3'd2, 16'hFFFE, 1'b0});
    end
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b1, 3'd3, 16'h0008, 1'b0}) begin
      bad++; $display("FAIL b2b_sll: got %h want %h", {enable_write, RW, BusW, zero}, {1'b1, 3'd3, 16'h0008, 1'b0});
    end
    tick();
    total++;
    if (enable_write !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end: got %b want 0", enable_write); end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  ops [4] = '{3'b010, 3'b011, 3'b110, 3'b101};
    logic [15:0] as  [4] = '{16'hF0F0, 16'h0F00, 16'h8000, 16'hABCD};
    logic [15:0] bs  [4] = '{16'h3C3C, 16'h00F0, 16'h000F, 16'h0010};
    logic [15:0] exp [4] = '{16'h3030, 16'h0FF0, 16'h0001, 16'hABCD};
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 3'(i + 1), as[i], bs[i]);
      tick();
      drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
      tick();
      total++;
      if ({enable_write, RW, BusW, zero} !== {1'b1, 3'(i + 1), exp[i], 1'b0}) begin
        bad++; $display("FAIL logic_op%0d: got %h want %h", i, {enable_write, RW, BusW, zero}, {1'b1, 3'(i + 1), exp[i], 1'b0});
      end
    end
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 3'b100, 3'd0, 16'h00FF, 16'h0F0F);
    tick();
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b0, 3'd0, 16'h0FF0, 1'b0}) begin
      bad++; $display("FAIL rd_zero: got %h want %h", {enable_write, RW, BusW, zero}, {1'b0, 3'd0, 16'h0FF0, 1'b0});
    end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    drive(1'b1, 3'b111, 3'd4, 16'h0123, 16'h0100);
    tick();
    // next instruction held by upstream until accepted
    drive(1'b1, 3'b000, 3'd5, 16'h0010, 16'h0020);
    for (int unsigned k = 0; k < 16; k++) begin
      total++;
      if ({in_ready, busy, enable_write} !== 3'b010) begin
        bad++; $display("FAIL mul_stall%0d: got %b want 010", k, {in_ready, busy, enable_write});
      end
      if (k < 15) tick();
    end
    tick();
    total++;
    if ({enable_write, RW, BusW, zero, in_ready, busy} !== {1'b1, 3'd4, 16'h2300, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mul_wb: got %h want %h", {enable_write, RW, BusW, zero, in_ready, busy}, {1'b1, 3'd4, 16'h2300, 1'b0, 1'b1, 1'b0});
    end
    tick();
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    total++;
    if (enable_write !== 1'b0) begin bad++; $display("FAIL mul_pulse_end: got %b want 0", enable_write); end
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b1, 3'd5, 16'h0030, 1'b0}) begin
      bad++; $display("FAIL mul_follow_add: got %h want %h", {enable_write, RW, BusW, zero}, {1'b1, 3'd5, 16'h0030, 1'b0});
    end
  endtask

  task automatic test_mul_abort();
    int unsigned writes = 0;
    drive(1'b1, 3'b111, 3'd4, 16'h0003, 16'h0003);
    tick();
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    for (int unsigned k = 0; k < 7; k++) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({busy, in_ready, enable_write} !== 3'b000) begin
      bad++; $display("FAIL abort_in_reset: got %b want 000", {busy, in_ready, enable_write});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({busy, in_ready} !== 2'b01) begin
      bad++; $display("FAIL abort_release: got %b want 01", {busy, in_ready});
    end
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      if (enable_write === 1'b1) writes++;
    end
    total++;
    if (writes !== 0) begin bad++; $display("FAIL abort_no_wb: got %0d writes want 0", writes); end
  endtask
`else
  task automatic test_mul_disabled();
    drive(1'b1, 3'b111, 3'd5, 16'h0005, 16'h0007);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL nomul_ready: got %b want 1", in_ready); end
    tick();
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    total++;
    if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL nomul_busy: got %b want 10", {in_ready, busy}); end
    tick();
    total++;
    if ({enable_write, RW, BusW, zero} !== {1'b0, 3'd5, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL nomul_wb: got %h want %h", {enable_write, RW, BusW, zero}, {1'b0, 3'd5, 16'h0000, 1'b1});
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0);
    test_reset();
    test_back_to_back();
    test_logic_ops();
    test_rd_zero();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_mul_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
